pwm_voice_scheduler: RTL and testbench
======================================

PWM_VOICE_SCHEDULER -- requirements
Module: pwm_voice_scheduler

Interface
REQ-001 Parameter NUM_PADS, default 4: number of drum-pad requesters.
REQ-002 Parameter NOTE_LEN, default 24'd2_500_000: clk cycles a granted note plays.
REQ-003 Parameter GAP_LEN, default 24'd50_000: clk cycles of forced silence after each note.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port pad_hit  input  NUM_PADS  one-cycle hit pulse per pad.
REQ-007 Port pad_top  input  NUM_PADS*16  per-pad PWM period (Top) value; pad i at bits [16i+15:16i].
REQ-008 Port pwm_top  output  16  Top value driven to the PWM generator.
REQ-009 Port pwm_en  output  1  gate for the PWM generator output; 1 = tone audible.
REQ-010 Port active_pad  output  $clog2(NUM_PADS)  index of the pad most recently granted.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port dropped  output  1  one-cycle pulse when a hit is merged into an already-pending request.

Function
REQ-013 Block SHALL keep one pending bit per pad; set on the edge after pad_hit[i]; cleared on the edge pad i is granted; set wins over clear in the same cycle.
REQ-014 dropped SHALL pulse for exactly the cycle after pad_hit[i] arrives while pending[i] is already 1; no second request is queued.
REQ-015 FSM states: IDLE, PLAY, GAP; registered; single-cycle transitions.
REQ-016 IDLE: with any pending bit, grant one pad round-robin, searching from (last granted + 1) mod NUM_PADS; latch pad_top of the granted pad into pwm_top, update active_pad, load counter with NOTE_LEN-1, go to PLAY.
REQ-017 IDLE with no pending bits: remain in IDLE, pwm_en = 0, pwm_top and active_pad held.
REQ-018 PLAY: pwm_en = 1 unless latched pwm_top == 0 (rest: pwm_en = 0, timing unchanged); counter decrements once per cycle.
REQ-019 PLAY, counter == 0: load counter with GAP_LEN-1, go to GAP; pwm_en = 0 from that edge.
REQ-020 PLAY, pad_hit on active_pad (retrigger): reload counter with NOTE_LEN-1, latch current pad_top again, stay in PLAY; pending for that pad not set, dropped not pulsed.
REQ-021 GAP: pwm_en = 0; counter decrements; at 0 go to IDLE; hits during GAP only set pending bits.
REQ-022 Latency: hit on an idle block with nothing pending -> pwm_en high 2 cycles after the cycle pad_hit is sampled.
REQ-023 Counter is 24 bits; it SHALL NOT wrap below 0; NOTE_LEN and GAP_LEN of 0 or 1 both give a 1-cycle phase.
REQ-024 pwm_top SHALL change only on a grant or a retrigger, never mid-note from a pad_top change alone.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, pending = 0, counter = 0, pwm_top = 0, pwm_en = 0, active_pad = 0, busy = 0, dropped = 0, last-granted pointer = NUM_PADS-1 (first search starts at pad 0).
REQ-026 Reset asserted mid-note SHALL silence pwm_en asynchronously; no pending request survives reset.

Structure
REQ-027 Shared package pwm_sched_pkg SHALL hold the state enum (IDLE, PLAY, GAP), default NOTE_LEN/GAP_LEN constants and counter width.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last pointer in; one-hot grant, index, valid out), purely combinational.

Verification (NOTE_LEN=8, GAP_LEN=2, NUM_PADS=4)
REQ-029 Single hit pad 1 (pad_top=16'd1000) at cycle 0 -> pwm_en 1 in cycles 2..9, pwm_top=1000, active_pad=1, GAP cycles 10..11, busy 0 at cycle 12.
REQ-030 Simultaneous hits pads 0 and 2 from reset -> pad 0 plays first, pad 2 plays after the gap; then hits on 0 and 2 again -> pad 0 first (searching from 3).
REQ-031 Pad 3 hit twice while pad 0 plays -> dropped pulses once, pad 3 plays exactly once.
REQ-032 Pad 1 retriggered at 5th PLAY cycle -> note lasts 5+8 cycles total, no dropped, no extra note.
REQ-033 pad_top=0 granted -> pwm_en stays 0 for 8 PLAY cycles, busy high, timing identical.
REQ-034 rst_n pulled low at 3rd PLAY cycle with pad 2 pending -> pwm_en 0 immediately; after release, no note plays without a new hit.

Source files
------------

// File: rtl/pwm_voice_scheduler_pkg.sv
// Shared definitions for the PWM voice scheduler.
//   CNT_W         : width of the note/gap phase counter
//   DEF_NOTE_LEN  : default note length in clk cycles
//   DEF_GAP_LEN   : default silence length after each note
//   state_e       : scheduler FSM states
//   phase_load()  : counter load value for a phase length (0 and 1 both give 1 cycle)
package pwm_sched_pkg;

  localparam int unsigned CNT_W = 24;

  localparam logic [CNT_W-1:0] DEF_NOTE_LEN = 24'd2_500_000;
  localparam logic [CNT_W-1:0] DEF_GAP_LEN  = 24'd50_000;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_e;

  // Counter runs len-1 .. 0; a zero length is clamped so it never wraps.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_voice_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the previously granted requester; search starts at last_i+1
//   grant_o : one-hot grant (all zero when nothing requested)
//   idx_o   : index of the granted requester
//   valid_o : a grant was made
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned p;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    p       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      p = (32'(last_i) + k) % N;
      if (!valid_o && req_i[p]) begin
        valid_o    = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/pwm_voice_scheduler.sv
// Drum-pad voice scheduler: queues pad hits, grants one pad at a time
// round-robin, plays its tone for NOTE_LEN cycles then forces GAP_LEN
// cycles of silence.
//   clk, rst_n : clock, asynchronous active-low reset
//   pad_hit    : one-cycle hit pulse per pad
//   pad_top    : per-pad PWM Top value, pad i at [16i+15:16i]
//   pwm_top    : Top value latched for the current note
//   pwm_en     : tone audible (PLAY with non-zero Top)
//   active_pad : most recently granted pad
//   busy       : scheduler not idle
//   dropped    : a hit was merged into an already-pending request
module pwm_voice_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int unsigned      NUM_PADS = 4,
  parameter logic [CNT_W-1:0] NOTE_LEN = DEF_NOTE_LEN,
  parameter logic [CNT_W-1:0] GAP_LEN  = DEF_GAP_LEN,
  localparam int unsigned     IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PADS-1:0]    pad_hit,
  input  logic [NUM_PADS*16-1:0] pad_top,
  output logic [15:0]            pwm_top,
  output logic                   pwm_en,
  output logic [IDX_W-1:0]       active_pad,
  output logic                   busy,
  output logic                   dropped
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PADS-1:0]   pend_q, pend_d;
  logic [15:0]           top_q, top_d;
  logic [IDX_W-1:0]      act_q, act_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  drop_q, drop_d;

  logic [15:0]           tops [NUM_PADS];
  logic [NUM_PADS-1:0]   gnt_vec;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_valid;
  logic                  retrig;
  logic [NUM_PADS-1:0]   retrig_mask;
  logic [NUM_PADS-1:0]   new_hits;
  logic [NUM_PADS-1:0]   grant_clr;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      tops[i] = pad_top[16*i +: 16];
    end
  end

  rr_arbiter #(
    .N     (NUM_PADS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (pend_q),
    .last_i  (last_q),
    .grant_o (gnt_vec),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // A hit on the pad currently sounding restarts the note instead of queuing.
  assign retrig      = (state_q == PLAY) && pad_hit[act_q];
  assign retrig_mask = retrig ? (NUM_PADS'(1) << act_q) : '0;
  assign new_hits    = pad_hit & ~retrig_mask;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    act_d     = act_q;
    last_d    = last_q;
    grant_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_clr = gnt_vec;
          top_d     = tops[gnt_idx];
          act_d     = gnt_idx;
          last_d    = gnt_idx;
          cnt_d     = phase_load(NOTE_LEN);
          state_d   = PLAY;
        end
      end
      PLAY: begin
        if (retrig) begin
          top_d = tops[act_q];
          cnt_d = phase_load(NOTE_LEN);
        end else if (cnt_q == '0) begin
          cnt_d   = phase_load(GAP_LEN);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A hit landing on the pad being granted this cycle starts a fresh
    // request rather than merging, so it is not reported as dropped.
    pend_d = (pend_q & ~grant_clr) | new_hits;
    drop_d = |(new_hits & pend_q & ~grant_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      top_q   <= '0;
      act_q   <= '0;
      last_q  <= IDX_W'(NUM_PADS - 1);
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      top_q   <= top_d;
      act_q   <= act_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign pwm_top    = top_q;
  assign active_pad = act_q;
  assign busy       = (state_q != IDLE);
  assign pwm_en     = (state_q == PLAY) && (top_q != '0);
  assign dropped    = drop_q;

endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// Scoreboard bench for pwm_voice_scheduler (NUM_PADS=4, NOTE_LEN=8, GAP_LEN=2).
// The reference model tracks notes as absolute-cycle deadlines; the driver
// pushes the expected outputs of each cycle, the negedge monitor pops them.
module tb_pwm_voice_scheduler;

  localparam int NP = 4;
  localparam int NL = 8;
  localparam int GL = 2;
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_GAP  = 2;

  typedef struct packed {
    logic        en;
    logic [15:0] top;
    logic [1:0]  act;
    logic        busy;
    logic        drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pad_hit = '0;
  logic [63:0] pad_top = '0;
  logic [15:0] pwm_top;
  logic        pwm_en;
  logic [1:0]  active_pad;
  logic        busy;
  logic        dropped;

  pwm_voice_scheduler #(
    .NUM_PADS (4),
    .NOTE_LEN (24'd8),
    .GAP_LEN  (24'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_hit    (pad_hit),
    .pad_top    (pad_top),
    .pwm_top    (pwm_top),
    .pwm_en     (pwm_en),
    .active_pad (active_pad),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  bit   armed  = 1'b0;

  // Reference model state
  int          cyc = 0;
  int          m_mode;
  bit [3:0]    m_pend;
  int          m_play_end, m_gap_end;
  logic [15:0] m_top;
  int          m_act, m_last;
  bit          m_drop;

  function automatic void model_reset();
    m_mode = M_IDLE; m_pend = '0; m_top = '0;
    m_act = 0; m_last = NP - 1; m_drop = 1'b0;
    m_play_end = 0; m_gap_end = 0;
  endfunction

  // Advance the model across the clock edge that ends cycle cyc.
  function automatic void model_step(input logic [3:0] h, input logic [63:0] pt);
    bit [3:0] clr  = '0;
    bit [3:0] newh = h;
    case (m_mode)
      M_PLAY: begin
        if (h[m_act]) begin
          newh[m_act] = 1'b0;
          m_play_end  = cyc + NL;
          m_top       = pt[m_act*16 +: 16];
        end else if (cyc == m_play_end) begin
          m_mode    = M_GAP;
          m_gap_end = cyc + GL;
        end
      end
      M_GAP: if (cyc == m_gap_end) m_mode = M_IDLE;
      default: begin
        if (m_pend != '0) begin
          for (int k = 1; k <= NP; k++) begin
            int p = (m_last + k) % NP;
            if (clr == '0 && m_pend[p]) begin
              clr[p]     = 1'b1;
              m_top      = pt[p*16 +: 16];
              m_act      = p;
              m_last     = p;
              m_mode     = M_PLAY;
              m_play_end = cyc + NL;
            end
          end
        end
      end
    endcase
    m_drop = |(newh & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | newh;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.en   = (m_mode == M_PLAY) && (m_top != 16'd0);
    e.top  = m_top;
    e.act  = m_act[1:0];
    e.busy = (m_mode != M_IDLE);
    e.drop = m_drop;
    return e;
  endfunction

  // One clock: update the model for the edge, queue the cycle's expectation,
  // then drive this cycle's hits.
  task automatic tick(input logic [3:0] h);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(pad_hit, pad_top);
    cyc++;
    q.push_back(model_out());
    armed = 1'b1;
    #1 pad_hit = h;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000);
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge.
  task automatic mid_reset();
    #1 rst_n = 1'b0;
    pad_hit = '0;
    #1;
    check1("async_pwm_en", pwm_en, 1'b0);
    check1("async_busy", busy, 1'b0);
    model_reset();
    q.delete();
    q.push_back(model_out());
    tick(4'b0000);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (armed) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL scoreboard_empty got=no_expectation want=one t=%0t", $time);
      end else begin
        e = q.pop_front();
        a = '{en: pwm_en, top: pwm_top, act: active_pad, busy: busy, drop: dropped};
        if (a === e) passed++;
        else $display("FAIL cycle_outputs t=%0t got en=%b top=%0d act=%0d busy=%b drop=%b want en=%b top=%0d act=%0d busy=%b drop=%b",
                      $time, a.en, a.top, a.act, a.busy, a.drop, e.en, e.top, e.act, e.busy, e.drop);
      end
    end
  end

  initial begin
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Single hit on pad 1
    pad_top[16 +: 16] = 16'd1000;
    tick(4'b0010); idle(14);

    // Simultaneous hits 0 and 2 from reset, then again
    mid_reset();
    pad_top[0 +: 16] = 16'd300; pad_top[32 +: 16] = 16'd700;
    tick(4'b0101); idle(26);
    tick(4'b0101); idle(26);

    // Pad 3 hit twice while pad 0 plays
    pad_top[48 +: 16] = 16'd4242;
    tick(4'b0001); idle(3);
    tick(4'b1000); tick(4'b0000); tick(4'b1000); idle(30);

    // Retrigger pad 1 at its 5th PLAY cycle, with a new Top
    tick(4'b0010); idle(5);
    pad_top[16 +: 16] = 16'd1234;
    tick(4'b0010); idle(20);

    // Rest note (Top = 0)
    pad_top[32 +: 16] = 16'd0;
    tick(4'b0100); idle(15);

    // Reset at 3rd PLAY cycle with pad 2 pending
    pad_top[0 +: 16] = 16'd500; pad_top[32 +: 16] = 16'd900;
    tick(4'b0001); tick(4'b0100); idle(3);
    mid_reset();
    idle(20);

    // Randomized traffic, including mid-note Top changes and rare resets
    for (int i = 0; i < 800; i++) begin
      logic [3:0] h;
      for (int k = 0; k < NP; k++) h[k] = ($urandom_range(0, 11) == 0);
      tick(h);
      if ($urandom_range(0, 4) == 0) begin
        int k = $urandom_range(0, NP - 1);
        pad_top[k*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) mid_reset();
    end
    idle(20);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
